// File: rtl/draw_enemy.sv
// Enemy sprite compositor: draws a solid rectangle over the background pixel
// stream, with per-frame position capture and a blinking death sequence.
module draw_enemy #(
  parameter int          WIDTH        = 32,
  parameter int          HEIGHT       = 32,
  parameter logic [11:0] COLOR        = 12'hF00,
  parameter int          BLINK_FRAMES = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        on,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [4:0]  CNT_LAST = 5'(BLINK_FRAMES - 1);
  localparam logic [12:0] WIDTH_13 = 13'(WIDTH);
  localparam logic [12:0] HEIGHT_13 = 13'(HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIVE = 2'd1,
    ST_DYING = 2'd2
  } state_e;

  // Frame-boundary detection and frame registers
  logic        vblnk_prev_q;
  logic        capture_s;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        on_q, on_d;

  // FSM
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        visible_s;

  // Pipeline stage 1
  logic [10:0] hcount_s1_q, vcount_s1_q;
  logic        hsync_s1_q, vsync_s1_q, hblnk_s1_q, vblnk_s1_q;
  logic [11:0] rgb_s1_q;
  logic        inside_s1_q;
  logic        inside_s;

  // Pipeline stage 2
  logic [10:0] hcount_s2_q, vcount_s2_q;
  logic        hsync_s2_q, vsync_s2_q, hblnk_s2_q, vblnk_s2_q;
  logic [11:0] rgb_s2_q, rgb_d;

  // A capture is the first cycle of vertical blanking.
  assign capture_s = vblnk_in & ~vblnk_prev_q;

  // Previous-vblnk register for edge detection.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
    end
  end

  // Frame registers: sampled only at the frame boundary so the sprite never tears.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    on_d = on_q;
    if (capture_s) begin
      x_d  = xpos;
      y_d  = ypos;
      on_d = on;
    end else begin
      x_d  = x_q;
      y_d  = y_q;
      on_d = on_q;
    end
  end

  // Frame register storage.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      x_q  <= 12'd0;
      y_q  <= 12'd0;
      on_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      on_q <= on_d;
    end
  end

  // FSM state and blink counter.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: advances once per frame, driven by the freshly captured flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (capture_s) begin
      case (state_q)
        ST_IDLE: begin
          if (on) begin
            state_d = ST_ALIVE;
          end else begin
            state_d = ST_IDLE;
          end
          cnt_d = 5'd0;
        end
        ST_ALIVE: begin
          if (on) begin
            state_d = ST_ALIVE;
          end else begin
            state_d = ST_DYING;
          end
          cnt_d = 5'd0;
        end
        ST_DYING: begin
          if (on) begin
            state_d = ST_ALIVE;
            cnt_d   = 5'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
          end else begin
            state_d = ST_DYING;
            cnt_d   = cnt_q + 5'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // FSM output: blink shows the sprite on even frames of the death sequence.
  always_comb begin
    visible_s = 1'b0;
    case (state_q)
      ST_IDLE:  visible_s = 1'b0;
      ST_ALIVE: visible_s = 1'b1;
      ST_DYING: visible_s = ~cnt_q[0];
      default:  visible_s = 1'b0;
    endcase
  end

  // Rectangle hit test in 13 bits so x+WIDTH never wraps near the edge.
  always_comb begin
    logic [12:0] hc_13, vc_13, x_13, y_13;
    hc_13    = {2'b00, hcount_in};
    vc_13    = {2'b00, vcount_in};
    x_13     = {1'b0, x_q};
    y_13     = {1'b0, y_q};
    inside_s = (hc_13 >= x_13) && (hc_13 < (x_13 + WIDTH_13)) &&
               (vc_13 >= y_13) && (vc_13 < (y_13 + HEIGHT_13));
  end

  // Stage 1: register timing, background colour and hit result.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_s1_q <= 11'd0;
      vcount_s1_q <= 11'd0;
      hsync_s1_q  <= 1'b0;
      vsync_s1_q  <= 1'b0;
      hblnk_s1_q  <= 1'b0;
      vblnk_s1_q  <= 1'b0;
      rgb_s1_q    <= 12'd0;
      inside_s1_q <= 1'b0;
    end else begin
      hcount_s1_q <= hcount_in;
      vcount_s1_q <= vcount_in;
      hsync_s1_q  <= hsync_in;
      vsync_s1_q  <= vsync_in;
      hblnk_s1_q  <= hblnk_in;
      vblnk_s1_q  <= vblnk_in;
      rgb_s1_q    <= rgb_in;
      inside_s1_q <= inside_s;
    end
  end

  // Stage 2 colour select: blanking forces black regardless of the sprite.
  always_comb begin
    rgb_d = rgb_s1_q;
    if (hblnk_s1_q || vblnk_s1_q) begin
      rgb_d = 12'h000;
    end else if (inside_s1_q && visible_s) begin
      rgb_d = COLOR;
    end else begin
      rgb_d = rgb_s1_q;
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_s2_q <= 11'd0;
      vcount_s2_q <= 11'd0;
      hsync_s2_q  <= 1'b0;
      vsync_s2_q  <= 1'b0;
      hblnk_s2_q  <= 1'b0;
      vblnk_s2_q  <= 1'b0;
      rgb_s2_q    <= 12'd0;
    end else begin
      hcount_s2_q <= hcount_s1_q;
      vcount_s2_q <= vcount_s1_q;
      hsync_s2_q  <= hsync_s1_q;
      vsync_s2_q  <= vsync_s1_q;
      hblnk_s2_q  <= hblnk_s1_q;
      vblnk_s2_q  <= vblnk_s1_q;
      rgb_s2_q    <= rgb_d;
    end
  end

  assign hcount_out = hcount_s2_q;
  assign vcount_out = vcount_s2_q;
  assign hsync_out  = hsync_s2_q;
  assign vsync_out  = vsync_s2_q;
  assign hblnk_out  = hblnk_s2_q;
  assign vblnk_out  = vblnk_s2_q;
  assign rgb_out    = rgb_s2_q;

endmodule

// File: tb/tb_draw_enemy.sv
// Randomized scoreboard bench for draw_enemy: a frame-level behavioural model
// predicts every output pixel; a monitor compares two cycles later.
`timescale 1ns/1ps
module tb_draw_enemy;

  localparam int          W     = 32;
  localparam int          H     = 32;
  localparam logic [11:0] COL   = 12'hF00;
  localparam int          BF    = 16;

  logic        pclk, rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, xpos, ypos, rgb_out;
  logic        on;

  draw_enemy #(.WIDTH(W), .HEIGHT(H), .COLOR(COL), .BLINK_FRAMES(BF)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .on(on),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  initial pclk = 1'b0;
  always #12.5 pclk = ~pclk;

  typedef struct {
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rst_pending;

  // Behavioural model state: what the enemy looks like this frame.
  int m_x, m_y;
  bit m_alive;
  int m_dying;      // blink frame index, -1 when not dying
  bit m_prev_vb;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_alive = 1'b0; m_dying = -1; m_prev_vb = 1'b0;
  endtask

  task automatic drive_cycle(input logic [10:0] hc, input logic [10:0] vc,
                             input logic hs, input logic vs, input logic hb, input logic vb,
                             input logic [11:0] rgb, input logic [11:0] x, input logic [11:0] y,
                             input logic on_v);
    exp_t e;
    exp_t z;
    bit   cap, ins, vis;
    @(negedge pclk);
    if (rst_pending) begin
      rst = 1'b0;
      rst_pending = 1'b0;
      z.hc = 11'd0; z.vc = 11'd0; z.hs = 1'b0; z.vs = 1'b0; z.hb = 1'b0; z.vb = 1'b0; z.rgb = 12'd0;
      q.push_back(z);
    end
    hcount_in = hc; vcount_in = vc; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb; xpos = x; ypos = y; on = on_v;
    cap = vb && !m_prev_vb;
    ins = (int'(hc) >= m_x) && (int'(hc) < m_x + W) && (int'(vc) >= m_y) && (int'(vc) < m_y + H);
    if (cap) begin
      m_x = int'(x);
      m_y = int'(y);
      if (on_v) begin
        m_alive = 1'b1; m_dying = -1;
      end else if (m_alive) begin
        m_alive = 1'b0; m_dying = 0;
      end else if (m_dying >= 0) begin
        m_dying = m_dying + 1;
        if (m_dying == BF) m_dying = -1;
      end
    end
    m_prev_vb = vb;
    vis = m_alive || (m_dying >= 0 && (m_dying % 2) == 0);
    e.hc = hc; e.vc = vc; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    e.rgb = (hb || vb) ? 12'h000 : ((ins && vis) ? COL : rgb);
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 39'd0) begin
      errors++;
      $display("FAIL %s: outputs h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h, required all zero",
               name, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out);
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    model_reset();
    q.delete();
    rst_pending = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge pclk);
  endtask

  function automatic logic [10:0] near(input int c, input int span);
    int lo;
    lo = (c > 3) ? c - 3 : 0;
    if ($urandom_range(0, 1) == 0) return 11'($urandom_range(lo, c + span + 3));
    else return 11'($urandom_range(0, 1055));
  endfunction

  // One synthetic frame: 4 vblank cycles (capture on the first) then active pixels.
  task automatic run_frame(input int cx, input int cy, input bit con, input int rst_at);
    logic [10:0] hc, vc;
    for (int i = 0; i < 4; i++) begin
      if (i == 0)
        drive_cycle(11'($urandom_range(0, 1055)), 11'(600 + i), 1'($urandom), 1'b1, 1'($urandom), 1'b1,
                    12'($urandom), 12'(cx), 12'(cy), con);
      else
        drive_cycle(11'($urandom_range(0, 1055)), 11'(600 + i), 1'($urandom), 1'b1, 1'($urandom), 1'b1,
                    12'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 240; i++) begin
      if (i == rst_at) do_reset();
      hc = near(cx, W);
      vc = near(cy, H);
      drive_cycle(hc, vc, 1'($urandom), 1'b0, (hc >= 11'd800) || ($urandom_range(0, 7) == 0), 1'b0,
                  12'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
    end
  endtask

  // Monitor: outputs are valid every cycle; zero while reset, else scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (rst) begin
        check_zero("reset_hold");
      end else if (q.size() >= 2) begin
        e = q.pop_front();
        checks++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
            {e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}) begin
          errors++;
          $display("FAIL timing: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                   hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                   e.hc, e.vc, e.hs, e.vs, e.hb, e.vb);
        end
        checks++;
        if (rgb_out !== e.rgb) begin
          errors++;
          $display("FAIL rgb at h=%0d v=%0d: got %h, expected %h", e.hc, e.vc, rgb_out, e.rgb);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rst_pending = 1'b1;
    hcount_in = 11'd0; vcount_in = 11'd0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'd0; xpos = 12'd0; ypos = 12'd0; on = 1'b0;
    model_reset();
    repeat (3) @(negedge pclk);

    run_frame(100, 100, 1'b0, -1);                        // pass-through only
    run_frame(200, 150, 1'b1, -1);
    run_frame(200, 150, 1'b1, -1);
    run_frame(400, 150, 1'b1, -1);                        // move after boundary
    run_frame(780, 150, 1'b1, -1);                        // right-edge clip
    for (int f = 0; f < 18; f++) run_frame(400, 150, 1'b0, -1);   // full blink then idle
    run_frame(300, 300, 1'b1, -1);
    for (int f = 0; f < 5; f++) run_frame(300, 300, 1'b0, -1);    // blink frames 0..4
    run_frame(300, 300, 1'b1, -1);                        // respawn at frame 5
    run_frame(300, 300, 1'b1, -1);
    for (int f = 0; f < 3; f++) run_frame(500, 200, 1'b0, -1);
    run_frame(500, 200, 1'b0, 100);                       // reset mid-blink
    run_frame(500, 200, 1'b0, -1);
    run_frame(500, 200, 1'b1, -1);
    run_frame(500, 200, 1'b1, -1);
    do_reset();
    run_frame(10, 20, 1'b1, -1);                          // capture on first cycle after release
    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(0, 820), $urandom_range(0, 620), 1'($urandom), -1);
    repeat (3) drive_cycle(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b0);
    @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_enemy.md
DRAW_ENEMY -- requirements
Module: draw_enemy

Interface
Parameters:
REQ-001 WIDTH, 32, enemy rectangle width in pixels.
REQ-002 HEIGHT, 32, enemy rectangle height in pixels.
REQ-003 COLOR, 12'hF00, enemy fill colour (4:4:4 RGB).
REQ-004 BLINK_FRAMES, 16, length of the death-blink sequence in frames (range 2..31).

Ports:
REQ-005 pclk  in  1  pixel clock, 40 MHz; the only clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 hcount_in, vcount_in  in  11 each  current pixel position from the timing chain.
REQ-008 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA sync and blanking.
REQ-009 rgb_in  in  12  background pixel colour.
REQ-010 xpos, ypos  in  12 each  enemy top-left corner, from ctl_enemy.
REQ-011 on  in  1  enemy alive flag, from ctl_enemy.
REQ-012 hcount_out, vcount_out  out  11 each  hcount_in, vcount_in delayed 2 cycles.
REQ-013 hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  the corresponding inputs delayed 2 cycles.
REQ-014 rgb_out  out  12  composited pixel, aligned with the delayed timing outputs.

Function
REQ-015 Frame-boundary capture: on the cycle vblnk_in is 1 and its registered previous value is 0, the block SHALL load xpos, ypos and on into frame registers; otherwise the frame registers SHALL hold their value.
REQ-016 Changes on xpos, ypos or on outside a capture cycle SHALL have no effect until the next capture (no tearing).
REQ-017 The FSM SHALL have three states: IDLE, ALIVE, DYING; it SHALL update only on capture cycles.
REQ-018 IDLE -> ALIVE when captured on=1; IDLE stays IDLE when on=0.
REQ-019 ALIVE stays ALIVE while on=1; ALIVE -> DYING with frame counter cleared to 0 when on=0.
REQ-020 DYING: the frame counter SHALL increment by 1 per capture; once counter = BLINK_FRAMES-1, the next capture SHALL move to IDLE, or to ALIVE if on=1.
REQ-021 DYING -> ALIVE immediately when captured on=1 (respawn aborts the blink).
REQ-022 visible SHALL be 1 in ALIVE, counter[0]=0 in DYING, and 0 in IDLE.
REQ-023 Stage 1 SHALL register all timing inputs and rgb_in, together with inside = (hcount_in >= x) and (hcount_in < x+WIDTH) and (vcount_in >= y) and (vcount_in < y+HEIGHT).
REQ-024 The comparisons in REQ-023 SHALL use the frame registers, be evaluated in 13-bit unsigned arithmetic (no wrap), and clip naturally at the screen edge.
REQ-025 Stage 2 SHALL register the stage-1 timing signals to the timing outputs.
REQ-026 Stage 2 SHALL set rgb_out = 12'h000 if hblnk or vblnk; else COLOR if inside and visible; else the stage-1 rgb.
REQ-027 Latency SHALL be exactly 2 pclk cycles from any input to its output, with no bubbles.

Reset
REQ-028 While rst=1, all outputs SHALL be 0, the FSM SHALL be IDLE, the frame counter 0, the frame registers 0, and the previous-vblnk register 0.
REQ-029 A reset asserted mid-frame or mid-blink SHALL abort the operation immediately (asynchronously).
REQ-030 After reset deasserts, no enemy SHALL be drawn until the first capture with on=1.
REQ-031 If a vblnk rising edge occurs in the first cycle after reset release, it SHALL be treated as a valid capture.

Verification
REQ-032 Pipeline: on=0, rgb_in=12'h0AB at hcount 100 -> rgb_out=12'h0AB two cycles later, with all timing outputs matching inputs delayed 2 cycles.
REQ-033 Draw: capture xpos=200, ypos=150, on=1 -> next frame, rgb_out=12'hF00 for hcount 200..231 and vcount 150..181; hcount 199 and 232 show rgb_in.
REQ-034 No tearing: xpos changed to 400 mid-frame -> rectangle stays at 200 for the rest of the frame and moves to 400 after the next vblnk edge.
REQ-035 Clip and blank: xpos=780 -> colour drawn only for hcount 780..799; rgb_out=0 during blanking even inside the rectangle range.
REQ-036 Death blink: on 1->0 captured -> drawn in frames 0,2,...,14 and absent in frames 1,3,...,15; IDLE after 16 frames; on=1 at frame 5 -> solid ALIVE from the next frame.
REQ-037 Reset: rst pulsed for 50 ns during DYING -> outputs 0 at once, then FSM IDLE with nothing drawn until a capture with on=1.
